// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared FSM encoding and fixed widths for the data-memory responder.
// Optional build macro used by this slice: DMEM_ERR_EN (adds dm_o_err to the bus).
package dmem_responder_pkg;

   localparam int DM_BE_WIDTH  = 4;
   localparam int DM_CNT_WIDTH = 4;

   typedef enum logic [1:0] {
      DM_IDLE = 2'b00,
      DM_WAIT = 2'b01,
      DM_RESP = 2'b10
   } dm_state_e;

   // Merge the enabled byte lanes of new_word over old_word.
   function automatic logic [31:0] dm_lane_merge(input logic [31:0] old_word,
                                                 input logic [31:0] new_word,
                                                 input logic [DM_BE_WIDTH-1:0] be);
      logic [31:0] res_s;
      res_s = old_word;
      for (int i = 0; i < DM_BE_WIDTH; i++) begin
         if (be[i]) begin
            res_s[8*i +: 8] = new_word[8*i +: 8];
         end else begin
            res_s[8*i +: 8] = old_word[8*i +: 8];
         end
      end
      return res_s;
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: cyc/stb/we/be bus between the memory stage (master) and dmem_responder (slave).
// dm_o_err exists only when DMEM_ERR_EN is defined.
interface dmem_responder_if #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 5
);
   logic              dm_i_cyc;
   logic              dm_i_stb;
   logic              dm_i_we;
   logic [3:0]        dm_i_be;
   logic [AWIDTH-1:0] dm_i_load_addr;
   logic [AWIDTH-1:0] dm_i_store_addr;
   logic [DWIDTH-1:0] dm_i_data;
   logic [DWIDTH-1:0] dm_o_read_data;
   logic              dm_o_ack;
   logic              dm_o_stall;
`ifdef DMEM_ERR_EN
   logic              dm_o_err;
`endif

   modport master (
      output dm_i_cyc, dm_i_stb, dm_i_we, dm_i_be,
      output dm_i_load_addr, dm_i_store_addr, dm_i_data,
      input  dm_o_read_data, dm_o_ack, dm_o_stall
`ifdef DMEM_ERR_EN
      , input dm_o_err
`endif
   );

   modport slave (
      input  dm_i_cyc, dm_i_stb, dm_i_we, dm_i_be,
      input  dm_i_load_addr, dm_i_store_addr, dm_i_data,
      output dm_o_read_data, dm_o_ack, dm_o_stall
`ifdef DMEM_ERR_EN
      , output dm_o_err
`endif
   );
endinterface

// File: rtl/dmem_byte_ram.sv
// dmem_byte_ram: four byte-wide lanes of DEPTH entries, per-lane write enable,
// one registered read port that can also be forced to zero.
module dmem_byte_ram
   import dmem_responder_pkg::*;
#(
   parameter int DWIDTH = 32,
   parameter int DEPTH  = 8,
   parameter int AW     = 3
) (
   input  logic                   dm_clk,
   input  logic                   dm_rst,
   input  logic [AW-1:0]          addr,
   input  logic [DM_BE_WIDTH-1:0] lane_we,
   input  logic [DWIDTH-1:0]      wdata,
   input  logic                   rd_en,
   input  logic                   rd_clr,
   output logic [DWIDTH-1:0]      rdata
);
   localparam int LW = DWIDTH / DM_BE_WIDTH;

   for (genvar i = 0; i < DM_BE_WIDTH; i++) begin : g_lane
      logic [LW-1:0] mem_r [DEPTH];
      logic [LW-1:0] rd_r;

      // Lane storage; contents deliberately survive reset
      always_ff @(posedge dm_clk) begin
         if (lane_we[i]) begin
            mem_r[addr] <= wdata[LW*i +: LW];
         end
      end

      // Registered read port; holds until the next load or clear
      always_ff @(posedge dm_clk or negedge dm_rst) begin
         if (!dm_rst) begin
            rd_r <= {LW{1'b0}};
         end else if (rd_clr) begin
            rd_r <= {LW{1'b0}};
         end else if (rd_en) begin
            rd_r <= mem_r[addr];
         end
      end

      assign rdata[LW*i +: LW] = rd_r;
   end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the data-memory bus; one request at a time, fixed wait, one-cycle ack.
// Build macro DMEM_ERR_EN adds dm_o_err for out-of-range words and empty stores.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DWIDTH      = 32,
   parameter int AWIDTH      = 5,
   parameter int DEPTH       = 8,
   parameter int WAIT_CYCLES = 0
) (
   input logic             dm_clk,
   input logic             dm_rst,
   dmem_responder_if.slave bus
);
   localparam int RAM_AW = $clog2(DEPTH);
   localparam logic [DM_CNT_WIDTH-1:0] WAIT_INIT =
      (WAIT_CYCLES == 0) ? {DM_CNT_WIDTH{1'b0}} : DM_CNT_WIDTH'(WAIT_CYCLES - 1);

   dm_state_e               state_r, state_s;
   logic [DM_CNT_WIDTH-1:0] cnt_r, cnt_s;
   logic                    commit_s;
   logic                    accept_s;

   logic                    req_we_r;
   logic [DM_BE_WIDTH-1:0]  req_be_r;
   logic [DWIDTH-1:0]       req_data_r;
   logic [AWIDTH-1:0]       req_addr_r;

   logic                    cur_we_s;
   logic [DM_BE_WIDTH-1:0]  cur_be_s;
   logic [DWIDTH-1:0]       cur_data_s;
   logic [AWIDTH-1:0]       cur_addr_s;
   logic [AWIDTH-1:0]       word_s;
   logic [RAM_AW-1:0]       ram_addr_s;
   logic                    err_s;

   logic [DM_BE_WIDTH-1:0]  ram_we_s;
   logic                    ram_rd_s;
   logic                    ram_clr_s;

   logic                    ack_r;
   logic                    stall_r;

   assign accept_s = (state_r == DM_IDLE) && bus.dm_i_cyc && bus.dm_i_stb;

   // With zero wait the commit edge is the capture edge, so IDLE uses the live bus
   always_comb begin
      if (state_r == DM_IDLE) begin
         cur_we_s   = bus.dm_i_we;
         cur_be_s   = bus.dm_i_be;
         cur_data_s = bus.dm_i_data;
         cur_addr_s = bus.dm_i_we ? bus.dm_i_store_addr : bus.dm_i_load_addr;
      end else begin
         cur_we_s   = req_we_r;
         cur_be_s   = req_be_r;
         cur_data_s = req_data_r;
         cur_addr_s = req_addr_r;
      end
   end

   assign word_s     = cur_addr_s >> 2;
   assign ram_addr_s = RAM_AW'(word_s % AWIDTH'(DEPTH));

`ifdef DMEM_ERR_EN
   assign err_s = (word_s >= AWIDTH'(DEPTH)) || (cur_we_s && (cur_be_s == 4'b0000));
`else
   assign err_s = 1'b0;
`endif

   // Next-state and commit strobe
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      commit_s = 1'b0;
      case (state_r)
         DM_IDLE: begin
            if (accept_s) begin
               if (WAIT_CYCLES == 0) begin
                  state_s  = DM_RESP;
                  commit_s = 1'b1;
               end else begin
                  state_s = DM_WAIT;
                  cnt_s   = WAIT_INIT;
               end
            end else begin
               state_s = DM_IDLE;
            end
         end
         DM_WAIT: begin
            if (cnt_r == {DM_CNT_WIDTH{1'b0}}) begin
               state_s  = DM_RESP;
               commit_s = 1'b1;
            end else begin
               cnt_s = cnt_r - {{(DM_CNT_WIDTH-1){1'b0}}, 1'b1};
            end
         end
         DM_RESP: begin
            state_s = DM_IDLE;
         end
         default: begin
            state_s = DM_IDLE;
            cnt_s   = {DM_CNT_WIDTH{1'b0}};
         end
      endcase
   end

   // FSM state and wait counter
   always_ff @(posedge dm_clk or negedge dm_rst) begin
      if (!dm_rst) begin
         state_r <= DM_IDLE;
         cnt_r   <= {DM_CNT_WIDTH{1'b0}};
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end
   end

   // Request latch, loaded only on acceptance
   always_ff @(posedge dm_clk or negedge dm_rst) begin
      if (!dm_rst) begin
         req_we_r   <= 1'b0;
         req_be_r   <= {DM_BE_WIDTH{1'b0}};
         req_data_r <= {DWIDTH{1'b0}};
         req_addr_r <= {AWIDTH{1'b0}};
      end else if (accept_s) begin
         req_we_r   <= cur_we_s;
         req_be_r   <= cur_be_s;
         req_data_r <= cur_data_s;
         req_addr_r <= cur_addr_s;
      end
   end

   assign ram_we_s  = (commit_s && cur_we_s && !err_s) ? cur_be_s : {DM_BE_WIDTH{1'b0}};
   assign ram_rd_s  = commit_s && !cur_we_s && !err_s;
   assign ram_clr_s = commit_s && err_s;

   dmem_byte_ram #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH),
      .AW     (RAM_AW)
   ) u_ram (
      .dm_clk  (dm_clk),
      .dm_rst  (dm_rst),
      .addr    (ram_addr_s),
      .lane_we (ram_we_s),
      .wdata   (cur_data_s),
      .rd_en   (ram_rd_s),
      .rd_clr  (ram_clr_s),
      .rdata   (bus.dm_o_read_data)
   );

   // Registered ack/stall, derived from the state being entered
   always_ff @(posedge dm_clk or negedge dm_rst) begin
      if (!dm_rst) begin
         ack_r   <= 1'b0;
         stall_r <= 1'b0;
      end else begin
         ack_r   <= (state_s == DM_RESP) && !err_s;
         stall_r <= (state_s != DM_IDLE);
      end
   end

   assign bus.dm_o_ack   = ack_r;
   assign bus.dm_o_stall = stall_r;

`ifdef DMEM_ERR_EN
   logic err_r;

   // Error pulse replaces ack in the response cycle
   always_ff @(posedge dm_clk or negedge dm_rst) begin
      if (!dm_rst) begin
         err_r <= 1'b0;
      end else begin
         err_r <= (state_s == DM_RESP) && err_s;
      end
   end

   assign bus.dm_o_err = err_r;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized scoreboard bench for dmem_responder (WAIT_CYCLES=3, DEPTH=4);
// works with and without DMEM_ERR_EN.
module tb_dmem_responder;
   localparam int TB_W  = 3;
   localparam int DEPTH = 4;

   typedef struct {
      int          k;
      bit          err;
      logic [31:0] rd;
   } exp_t;

   logic        dm_clk = 1'b0;
   logic        dm_rst = 1'b0;
   int          cyc_cnt = 0;
   int          pend_k = -100;
   int          n_cmp = 0;
   int          n_fail = 0;
   logic [31:0] model_mem [DEPTH];
   logic [31:0] last_rd = 32'h0;
   exp_t        q[$];

   dmem_responder_if #(.DWIDTH(32), .AWIDTH(5)) bus ();

   dmem_responder #(
      .DWIDTH      (32),
      .AWIDTH      (5),
      .DEPTH       (DEPTH),
      .WAIT_CYCLES (TB_W)
   ) dut (
      .dm_clk (dm_clk),
      .dm_rst (dm_rst),
      .bus    (bus)
   );

   always #5 dm_clk = ~dm_clk;
   always @(posedge dm_clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
      end
   endtask

   // Issue one single-cycle strobe; the reference model decides the response.
   task automatic issue(input bit we, input logic [3:0] be, input logic [4:0] la,
                        input logic [4:0] sa, input logic [31:0] d, input bit abort);
      int   idx;
      bit   er;
      exp_t e;
      idx = (we ? int'(sa) : int'(la)) / 4;
      er  = 1'b0;
`ifdef DMEM_ERR_EN
      er  = (idx >= DEPTH) || (we && be == 4'b0000);
`endif
      idx = idx % DEPTH;
      bus.dm_i_cyc = 1'b1; bus.dm_i_stb = 1'b1; bus.dm_i_we = we; bus.dm_i_be = be;
      bus.dm_i_load_addr = la; bus.dm_i_store_addr = sa; bus.dm_i_data = d;
      pend_k = cyc_cnt + 1;
      if (!abort) begin
         if (er) begin
            last_rd = 32'h0;
         end else if (we) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
         end else begin
            last_rd = model_mem[idx];
         end
         e.k = cyc_cnt + 1; e.err = er; e.rd = last_rd;
         q.push_back(e);
      end
      @(posedge dm_clk); #1;
      bus.dm_i_stb = 1'b0;
      bus.dm_i_cyc = 1'($urandom_range(0, 1));
   endtask

   // Throw junk strobes at the busy DUT until the response drains (bounded).
   task automatic wait_done();
      int n;
      n = 0;
      while (q.size() != 0 && n < 40) begin
         bus.dm_i_cyc = 1'($urandom_range(0, 1));
         bus.dm_i_stb = 1'($urandom_range(0, 1));
         bus.dm_i_we  = 1'($urandom_range(0, 1));
         bus.dm_i_be  = 4'($urandom);
         bus.dm_i_load_addr  = 5'($urandom);
         bus.dm_i_store_addr = 5'($urandom);
         bus.dm_i_data = $urandom;
         @(posedge dm_clk); #1;
         n++;
      end
      bus.dm_i_stb = 1'b0;
      bus.dm_i_cyc = 1'b0;
   endtask

   initial begin : monitor
      exp_t        e;
      logic        got_err;
      logic        got;
      logic        exp_stall;
      forever begin
         @(negedge dm_clk);
`ifdef DMEM_ERR_EN
         got_err = bus.dm_o_err;
`else
         got_err = 1'b0;
`endif
         got = bus.dm_o_ack | got_err;
         if (!dm_rst) begin
            check("rst_ack", 32'(bus.dm_o_ack), 32'd0);
            check("rst_stall", 32'(bus.dm_o_stall), 32'd0);
            check("rst_read_data", bus.dm_o_read_data, 32'd0);
            check("rst_err", 32'(got_err), 32'd0);
         end else begin
            exp_stall = (cyc_cnt >= pend_k) && (cyc_cnt <= pend_k + TB_W);
            check("stall", 32'(bus.dm_o_stall), 32'(exp_stall));
            if (q.size() != 0 && cyc_cnt > q[0].k + TB_W) begin
               check("ack_missing", 32'(got), 32'd1);
               void'(q.pop_front());
            end
            if (got) begin
               if (q.size() == 0) begin
                  check("spurious_ack", 32'(got), 32'd0);
               end else begin
                  e = q.pop_front();
                  check("latency", 32'(cyc_cnt - e.k), 32'(TB_W));
                  check("ack", 32'(bus.dm_o_ack), 32'(!e.err));
                  check("err", 32'(got_err), 32'(e.err));
                  check("read_data", bus.dm_o_read_data, e.rd);
               end
            end
         end
      end
   end

   initial begin : driver
      bit          we;
      logic [31:0] d;
      bus.dm_i_cyc = 1'b0; bus.dm_i_stb = 1'b0; bus.dm_i_we = 1'b0; bus.dm_i_be = 4'h0;
      bus.dm_i_load_addr = 5'd0; bus.dm_i_store_addr = 5'd0; bus.dm_i_data = 32'h0;
      repeat (3) @(posedge dm_clk);
      #1 dm_rst = 1'b1;

      for (int i = 0; i < DEPTH; i++) begin
         issue(1'b1, 4'hF, 5'd0, 5'(i * 4), $urandom, 1'b0);
         wait_done();
      end
      issue(1'b1, 4'hF, 5'd0, 5'd4, 32'hDEADBEEF, 1'b0); wait_done();
      issue(1'b0, 4'h0, 5'd4, 5'd0, 32'h0, 1'b0);        wait_done();
      issue(1'b1, 4'b0100, 5'd0, 5'd4, 32'h00AA0000, 1'b0); wait_done();
      issue(1'b0, 4'hF, 5'd4, 5'd0, 32'h0, 1'b0);        wait_done();

      // store to addr 8 aborted by reset while waiting
      issue(1'b1, 4'hF, 5'd0, 5'd8, 32'h12345678, 1'b1);
      dm_rst = 1'b0; pend_k = -100; last_rd = 32'h0;
      @(posedge dm_clk); #1 dm_rst = 1'b1;
      issue(1'b0, 4'h0, 5'd8, 5'd0, 32'h0, 1'b0);        wait_done();

      issue(1'b0, 4'h0, 5'd16, 5'd0, 32'h0, 1'b0);       wait_done();
      issue(1'b1, 4'h0, 5'd0, 5'd4, 32'hFFFFFFFF, 1'b0); wait_done();
      issue(1'b0, 4'h0, 5'd4, 5'd0, 32'h0, 1'b0);        wait_done();

      repeat (150) begin
         repeat ($urandom_range(0, 2)) begin
            bus.dm_i_cyc = 1'($urandom_range(0, 1));
            bus.dm_i_stb = bus.dm_i_cyc ? 1'b0 : 1'($urandom_range(0, 1));
            @(posedge dm_clk); #1;
         end
         we = 1'($urandom_range(0, 1));
         d  = $urandom;
         issue(we, 4'($urandom), 5'($urandom), 5'($urandom), d, 1'b0);
         wait_done();
      end

      repeat (6) @(posedge dm_clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
